// File: rtl/regular_sensor_decoder_pkg.sv
// Shared constants, state encoding and helpers for the regular sensor decoder
// and other sensor-side blocks.
package regular_sensor_decoder_pkg;

    localparam int SLOT_NUM = 16;
    localparam int SLOT_W   = 4;
    localparam int DATA_W   = 8;

    localparam logic [DATA_W-1:0] DATA_MAX  = 8'd255;
    localparam logic [SLOT_W-1:0] SLOT_LAST = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        DRAIN  = 2'd2
    } dec_state_e;

    // An address that never pulsed reports zero rather than stale storage.
    function automatic logic [DATA_W-1:0] entry_data(
        input logic              seen,
        input logic [DATA_W-1:0] value
    );
        logic [DATA_W-1:0] result;
        if (seen) begin
            result = value;
        end else begin
            result = {DATA_W{1'b0}};
        end
        return result;
    endfunction

endpackage

// File: rtl/sensor_frame_counter.sv
// Slot/data counter pair that walks one 4096-cycle sensor frame
// (16 slots per data step, 256 data steps), cycle-aligned with the sensors.
module sensor_frame_counter
    import regular_sensor_decoder_pkg::*;
(
    input  logic              clk_division,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear,
    output logic [SLOT_W-1:0] slot_cnt,
    output logic [DATA_W-1:0] data_cnt,
    output logic              frame_last
);

    logic [SLOT_W-1:0] slot_cnt_q;
    logic [SLOT_W-1:0] slot_cnt_d;
    logic [DATA_W-1:0] data_cnt_q;
    logic [DATA_W-1:0] data_cnt_d;

    // Next count: clear wins over enable, data steps when the slot wraps.
    always_comb begin
        slot_cnt_d = slot_cnt_q;
        data_cnt_d = data_cnt_q;
        if (clear) begin
            slot_cnt_d = {SLOT_W{1'b0}};
            data_cnt_d = {DATA_W{1'b0}};
        end else if (en) begin
            slot_cnt_d = slot_cnt_q + 4'd1;
            if (slot_cnt_q == SLOT_LAST) begin
                data_cnt_d = data_cnt_q + 8'd1;
            end else begin
                data_cnt_d = data_cnt_q;
            end
        end else begin
            slot_cnt_d = slot_cnt_q;
            data_cnt_d = data_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_division or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q <= {SLOT_W{1'b0}};
            data_cnt_q <= {DATA_W{1'b0}};
        end else begin
            slot_cnt_q <= slot_cnt_d;
            data_cnt_q <= data_cnt_d;
        end
    end

    assign slot_cnt   = slot_cnt_q;
    assign data_cnt   = data_cnt_q;
    assign frame_last = (slot_cnt_q == SLOT_LAST) && (data_cnt_q == DATA_MAX);

endmodule

// File: rtl/regular_sensor_decoder.sv
// Decodes one frame of time-slotted sensor pulses into 16 address/value entries
// drained over a valid/ready port. Optional duplicate tracking: SENSOR_DUP_CHECK_EN.
module regular_sensor_decoder
    import regular_sensor_decoder_pkg::*;
(
    input  logic              clk_division,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic              slot_line,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SLOT_W-1:0] out_address,
    output logic [DATA_W-1:0] out_data,
    output logic              out_missing,
    output logic              out_dup,
    output logic              busy,
    output logic              overrun
);

    dec_state_e        state_q;
    dec_state_e        state_d;
    logic [SLOT_W-1:0] rd_ptr_q;
    logic [SLOT_W-1:0] rd_ptr_d;
    logic              overrun_q;
    logic              overrun_d;
    logic [SLOT_NUM-1:0] seen_q;
    logic [SLOT_NUM-1:0] seen_d;
    logic [DATA_W-1:0] value_q [SLOT_NUM];

    logic              cnt_en_s;
    logic              cnt_clear_s;
    logic [SLOT_W-1:0] slot_cnt_s;
    logic [DATA_W-1:0] data_cnt_s;
    logic              frame_last_s;
    logic              sample_hit_s;
    logic              first_hit_s;
    logic              drain_s;

    sensor_frame_counter u_frame_counter (
        .clk_division (clk_division),
        .rst_n        (rst_n),
        .en           (cnt_en_s),
        .clear        (cnt_clear_s),
        .slot_cnt     (slot_cnt_s),
        .data_cnt     (data_cnt_s),
        .frame_last   (frame_last_s)
    );

    // Frame sequencing: start, sample window, drain handshake and overrun.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        overrun_d   = overrun_q;
        cnt_en_s    = 1'b0;
        cnt_clear_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_en) begin
                    state_d     = SAMPLE;
                    cnt_clear_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SAMPLE: begin
                cnt_en_s = 1'b1;
                if (sample_en) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (frame_last_s) begin
                    state_d  = DRAIN;
                    rd_ptr_d = {SLOT_W{1'b0}};
                end else begin
                    state_d = SAMPLE;
                end
            end
            DRAIN: begin
                // A start strobe here, including on the final handshake, is dropped.
                if (sample_en) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (out_ready) begin
                    if (rd_ptr_q == SLOT_LAST) begin
                        state_d  = IDLE;
                        rd_ptr_d = {SLOT_W{1'b0}};
                    end else begin
                        state_d  = DRAIN;
                        rd_ptr_d = rd_ptr_q + 4'd1;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d  = IDLE;
                rd_ptr_d = {SLOT_W{1'b0}};
            end
        endcase
    end

    // State, read pointer and sticky overrun registers.
    always_ff @(posedge clk_division or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_ptr_q  <= {SLOT_W{1'b0}};
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample_hit_s = (state_q == SAMPLE) && slot_line;
    assign first_hit_s  = sample_hit_s && !seen_q[slot_cnt_s];

    // Seen bits: cleared at frame start, set by the first pulse in a slot.
    always_comb begin
        seen_d = seen_q;
        if (cnt_clear_s) begin
            seen_d = {SLOT_NUM{1'b0}};
        end else if (first_hit_s) begin
            seen_d[slot_cnt_s] = 1'b1;
        end else begin
            seen_d = seen_q;
        end
    end

    // Seen register.
    always_ff @(posedge clk_division or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= {SLOT_NUM{1'b0}};
        end else begin
            seen_q <= seen_d;
        end
    end

    // Value store: only the first pulse of a slot writes, later pulses are ignored.
    always_ff @(posedge clk_division or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOT_NUM; i++) begin
                value_q[i] <= {DATA_W{1'b0}};
            end
        end else if (first_hit_s) begin
            value_q[slot_cnt_s] <= data_cnt_s;
        end
    end

    assign drain_s = (state_q == DRAIN);

`ifdef SENSOR_DUP_CHECK_EN
    logic [SLOT_NUM-1:0] dup_q;
    logic [SLOT_NUM-1:0] dup_d;

    // Dup bits: a pulse into an already-seen slot marks it.
    always_comb begin
        dup_d = dup_q;
        if (cnt_clear_s) begin
            dup_d = {SLOT_NUM{1'b0}};
        end else if (sample_hit_s && seen_q[slot_cnt_s]) begin
            dup_d[slot_cnt_s] = 1'b1;
        end else begin
            dup_d = dup_q;
        end
    end

    // Dup register.
    always_ff @(posedge clk_division or negedge rst_n) begin
        if (!rst_n) begin
            dup_q <= {SLOT_NUM{1'b0}};
        end else begin
            dup_q <= dup_d;
        end
    end

    assign out_dup = drain_s & dup_q[rd_ptr_q];
`else
    assign out_dup = 1'b0;
`endif

    // Entry outputs decode from registered state only and read zero outside DRAIN.
    always_comb begin
        out_valid   = 1'b0;
        out_address = {SLOT_W{1'b0}};
        out_data    = {DATA_W{1'b0}};
        out_missing = 1'b0;
        if (drain_s) begin
            out_valid   = 1'b1;
            out_address = rd_ptr_q;
            out_data    = entry_data(seen_q[rd_ptr_q], value_q[rd_ptr_q]);
            out_missing = ~seen_q[rd_ptr_q];
        end else begin
            out_valid   = 1'b0;
            out_address = {SLOT_W{1'b0}};
            out_data    = {DATA_W{1'b0}};
            out_missing = 1'b0;
        end
    end

    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

endmodule

// File: doc/regular_sensor_decoder.md
REGULAR_SENSOR_DECODER -- requirements
Module: regular_sensor_decoder

Interface
REQ-001 The block SHALL have no parameters; all sizes are fixed constants from the shared package.
REQ-002 The block SHALL have port clk_division, input, 1, the single clock (sensor-side divided clock), with all state updating on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port sample_en, input, 1, the frame-start strobe broadcast to all sensors.
REQ-005 The block SHALL have port slot_line, input, 1, the wired-OR of all 16 sensor slot outputs.
REQ-006 The block SHALL have port out_valid, output, 1, result entry available.
REQ-007 The block SHALL have port out_ready, input, 1, consumer accepts the entry.
REQ-008 The block SHALL have port out_address, output, 4, sensor address of the entry.
REQ-009 The block SHALL have port out_data, output, 8, decoded sensor value.
REQ-010 The block SHALL have port out_missing, output, 1, no pulse was seen for this address.
REQ-011 The block SHALL have port out_dup, output, 1, more than one pulse was seen for this address.
REQ-012 The block SHALL have port busy, output, 1, high in SAMPLE and DRAIN.
REQ-013 The block SHALL have port overrun, output, 1, sticky flag for a sample_en dropped outside IDLE.

Function
REQ-014 The block SHALL implement states IDLE, SAMPLE and DRAIN.
REQ-015 In IDLE, sample_en=1 at a clock edge SHALL enter SAMPLE with slot_cnt=0, data_cnt=0, and SHALL clear all seen/dup bits.
REQ-016 In SAMPLE, slot_cnt (4 bit) SHALL increment every cycle, and data_cnt (8 bit) SHALL increment when slot_cnt==15, both wrapping; this gives a frame of exactly 4096 cycles, cycle-aligned with the sensors.
REQ-017 In SAMPLE, slot_line=1 at an edge SHALL record data_cnt into value[slot_cnt] and set seen[slot_cnt] if it is clear; if it is already set, the value SHALL be kept (first pulse wins) and dup[slot_cnt] SHALL be set.
REQ-018 At slot_cnt==15 and data_cnt==255, after sampling that cycle, the block SHALL enter DRAIN with rd_ptr=0.
REQ-019 In DRAIN, the block SHALL hold out_valid=1 with out_address=rd_ptr, out_data=value[rd_ptr] (0 if not seen), out_missing=~seen[rd_ptr], out_dup=dup[rd_ptr].
REQ-020 Outputs SHALL stay stable while out_valid=1 and out_ready=0; out_valid=out_ready=1 SHALL advance rd_ptr.
REQ-021 A handshake with rd_ptr==15 SHALL return the block to IDLE with out_valid=0 on the next cycle.
REQ-022 The first entry SHALL be valid one cycle after the last sample edge.
REQ-023 The block SHALL ignore slot_line in IDLE and DRAIN.
REQ-024 sample_en=1 in SAMPLE or DRAIN SHALL be dropped and SHALL set overrun; overrun SHALL clear only on reset.
REQ-025 sample_en=1 in the same cycle as the final DRAIN handshake SHALL be dropped and SHALL set overrun.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE; counters, rd_ptr, seen, dup, values, overrun and all outputs SHALL go to 0.
REQ-027 Reset mid-SAMPLE or mid-DRAIN SHALL abandon the frame with no entries emitted.

Configuration
REQ-028 With SENSOR_DUP_CHECK_EN defined, dup tracking SHALL follow REQ-017 and REQ-019.
REQ-029 Without SENSOR_DUP_CHECK_EN, dup storage SHALL be omitted, out_dup SHALL be tied 0, and first-pulse-wins SHALL still apply.

Structure
REQ-030 The shared package SHALL hold SLOT_NUM=16, SLOT_W=4, DATA_W=8, DATA_MAX=255 and the state encoding enum.
REQ-031 The slot/data counter pair SHALL be a sub-module, sensor_frame_counter (en, clear, slot_cnt, data_cnt, frame_last), for reuse by sensor-side blocks.

Verification
REQ-032 Bench SHALL cover: 16 sensor models with address a and value 0x10+a, pulse sample_en -> entries a=0..15 with data 0x10+a, missing=0, dup=0; busy low after 4096+16 cycles with out_ready held 1.
REQ-033 Bench SHALL cover: sensor 5 absent -> entry 5 has missing=1, data=0; all other entries correct.
REQ-034 Bench SHALL cover: extra pulse on slot 3 at data_cnt 0x80 after the real pulse at 0x13 -> entry 3 data=0x13, dup=1 (dup=0 when the macro is undefined).
REQ-035 Bench SHALL cover: out_ready low for 10 cycles on entry 7 -> outputs stable throughout, no entry lost or repeated.
REQ-036 Bench SHALL cover: sample_en pulsed at cycle 2000 of SAMPLE -> overrun=1, frame result unchanged.
REQ-037 Bench SHALL cover: rst_n low during DRAIN at entry 4 -> all outputs 0 immediately; a following frame decodes correctly.
